// File: rtl/cm_deser_if.sv
// cm_deser_if: valid/ready bus bundle for the cm_deser stream deserializer.
// Input word stream (i_vld/o_rdy/i_data) and output frame stream (o_vld/i_rdy/o_data).
// Optional short-frame signals i_last/o_cnt exist only when CM_DESER_LAST_EN is defined.
interface cm_deser_if #(
    parameter int unsigned LEN   = 4,
    parameter type         DTYPE = logic [7:0]
);
    localparam int unsigned CNTW = $clog2(LEN + 1);

    logic             i_vld;
    logic             o_rdy;
    DTYPE             i_data;
    logic             o_vld;
    logic             i_rdy;
    DTYPE [LEN-1:0]   o_data;
`ifdef CM_DESER_LAST_EN
    logic             i_last;
    logic [CNTW-1:0]  o_cnt;

    modport slave  (input  i_vld, i_data, i_rdy, i_last,
                    output o_rdy, o_vld, o_data, o_cnt);
    modport master (output i_vld, i_data, i_rdy, i_last,
                    input  o_rdy, o_vld, o_data, o_cnt);
`else
    modport slave  (input  i_vld, i_data, i_rdy,
                    output o_rdy, o_vld, o_data);
    modport master (output i_vld, i_data, i_rdy,
                    input  o_rdy, o_vld, o_data);
`endif
endinterface

// File: rtl/cm_deser.sv
// cm_deser: gathers LEN consecutive words from a valid/ready stream into one
// parallel frame (o_data[0] = first word) on a valid/ready output stream.
// Full throughput: the completing word and the output beat may share a cycle.
// Optional feature macro: CM_DESER_LAST_EN (i_last terminates a short frame,
// unfilled slots are zero, o_cnt reports the number of valid words).
module cm_deser #(
    parameter int unsigned LEN   = 4,
    parameter type         DTYPE = logic [7:0]
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    cm_deser_if.slave   bus
);
    localparam int unsigned CW   = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int unsigned BW   = (LEN > 1) ? LEN - 1 : 1;
    localparam int unsigned CNTW = $clog2(LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(LEN - 1);

    if (LEN < 1) begin : g_len_chk
        $error("cm_deser: LEN must be >= 1");
    end

    logic [CW-1:0]   cnt_q, cnt_d;
    DTYPE [BW-1:0]   buf_q, buf_d;
    DTYPE [LEN-1:0]  out_q, out_d;
    logic            vld_q, vld_d;
    DTYPE [LEN-1:0]  frame;
    logic            completing;
    logic            in_beat;
    logic            out_beat;

`ifdef CM_DESER_LAST_EN
    logic [CNTW-1:0] ocnt_q, ocnt_d;
    assign completing = (cnt_q == CNT_LAST) || bus.i_last;
    assign bus.o_cnt  = ocnt_q;
`else
    assign completing = (cnt_q == CNT_LAST);
`endif

    // Only a completing word has to wait for the output register to drain.
    assign bus.o_rdy  = !completing || !vld_q || bus.i_rdy;
    assign in_beat    = bus.i_vld && bus.o_rdy;
    assign out_beat   = vld_q && bus.i_rdy;
    assign bus.o_vld  = vld_q;
    assign bus.o_data = out_q;

    // Next-state: collect words into the buffer, or assemble and publish a frame.
    always_comb begin
        cnt_d = cnt_q;
        buf_d = buf_q;
        out_d = out_q;
        vld_d = vld_q;
        frame = '0;
`ifdef CM_DESER_LAST_EN
        ocnt_d = ocnt_q;
`endif
        // Slots below cnt come from the buffer, slot cnt is the incoming word,
        // anything above stays zero (only reachable on a short frame).
        for (int unsigned i = 0; i < BW; i++) begin
            if (CW'(i) < cnt_q) begin
                frame[i] = buf_q[i];
            end
        end
        frame[cnt_q] = bus.i_data;

        if (out_beat) begin
            vld_d = 1'b0;
        end
        if (in_beat) begin
            if (completing) begin
                out_d = frame;
                vld_d = 1'b1;
                cnt_d = '0;
`ifdef CM_DESER_LAST_EN
                ocnt_d = CNTW'(cnt_q) + CNTW'(1);
`endif
            end else begin
                buf_d[cnt_q] = bus.i_data;
                cnt_d        = cnt_q + CW'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q  <= '0;
            buf_q  <= '0;
            out_q  <= '0;
            vld_q  <= 1'b0;
`ifdef CM_DESER_LAST_EN
            ocnt_q <= '0;
`endif
        end else begin
            cnt_q  <= cnt_d;
            buf_q  <= buf_d;
            out_q  <= out_d;
            vld_q  <= vld_d;
`ifdef CM_DESER_LAST_EN
            ocnt_q <= ocnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_cm_deser.sv
// Testbench for cm_deser: LEN=4 and LEN=1 instances against a queue-based
// reference model (words in, frames of LEN words out, in order).
module tb_cm_deser;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    cm_deser_if #(.LEN(4), .DTYPE(logic [7:0])) if4 ();
    cm_deser_if #(.LEN(1), .DTYPE(logic [7:0])) if1 ();

    cm_deser #(.LEN(4), .DTYPE(logic [7:0])) u_dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if4)
    );

    cm_deser #(.LEN(1), .DTYPE(logic [7:0])) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog time limit reached got=running exp=finished");
        $fatal(1, "watchdog");
    end

    // Reference model for LEN=4: partial words and frames waiting at the output.
    logic [7:0]  m_part[$];
    logic [31:0] m_frm[$];

    function automatic logic m_rdy(input logic r);
        return (m_part.size() != 3) || (m_frm.size() == 0) || r;
    endfunction

    task automatic apply4(input logic v, input logic [7:0] d, input logic r);
        if4.i_vld  = v;
        if4.i_data = d;
        if4.i_rdy  = r;
        #1;
    endtask

    task automatic adv4(input logic v, input logic [7:0] d, input logic r);
        logic ib, ob;
        ob = (m_frm.size() != 0) && r;
        ib = v && m_rdy(r);
        if (ob) void'(m_frm.pop_front());
        if (ib) begin
            m_part.push_back(d);
            if (m_part.size() == 4) begin
                m_frm.push_back({m_part[3], m_part[2], m_part[1], m_part[0]});
                m_part.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (if4.o_vld !== 1'b0) begin n_fail++; $display("FAIL reset_o_vld got=%0h exp=0", if4.o_vld); end
        n_chk++; if (if4.o_data !== 32'h0) begin n_fail++; $display("FAIL reset_o_data got=%0h exp=0", if4.o_data); end
        n_chk++; if (if4.o_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_o_rdy got=%0h exp=1", if4.o_rdy); end
        n_chk++; if (if1.o_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_o_rdy_len1 got=%0h exp=1", if1.o_rdy); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_part.delete();
        m_frm.delete();
        // one full frame held under backpressure, then two words of the next frame
        for (int i = 0; i < 4; i++) begin
            apply4(1'b1, 8'hA1 + 8'(i), 1'b1);
            adv4(1'b1, 8'hA1 + 8'(i), 1'b1);
        end
        for (int i = 0; i < 2; i++) begin
            apply4(1'b1, 8'hB1 + 8'(i), 1'b0);
            adv4(1'b1, 8'hB1 + 8'(i), 1'b0);
        end
        apply4(1'b0, 8'h00, 1'b0);
        n_chk++; if (if4.o_data !== 32'hA4A3A2A1) begin n_fail++; $display("FAIL pre_reset_frame got=%0h exp=a4a3a2a1", if4.o_data); end
        #1 rst_n = 1'b0;
        #1;
        n_chk++; if (if4.o_vld !== 1'b0) begin n_fail++; $display("FAIL midreset_o_vld got=%0h exp=0", if4.o_vld); end
        n_chk++; if (if4.o_data !== 32'h0) begin n_fail++; $display("FAIL midreset_o_data got=%0h exp=0", if4.o_data); end
        @(negedge clk);
        rst_n = 1'b1;
        m_part.delete();
        m_frm.delete();
        for (int i = 0; i < 4; i++) begin
            apply4(1'b1, 8'h11 * 8'(i + 1), 1'b1);
            n_chk++; if (if4.o_vld !== 1'b0) begin n_fail++; $display("FAIL postreset_o_vld cycle=%0d got=%0h exp=0", i, if4.o_vld); end
            adv4(1'b1, 8'h11 * 8'(i + 1), 1'b1);
        end
        apply4(1'b0, 8'h00, 1'b1);
        n_chk++; if (if4.o_vld !== 1'b1) begin n_fail++; $display("FAIL postreset_frame_vld got=%0h exp=1", if4.o_vld); end
        n_chk++; if (if4.o_data !== 32'h44332211) begin n_fail++; $display("FAIL postreset_frame got=%0h exp=44332211", if4.o_data); end
        adv4(1'b0, 8'h00, 1'b1);
    endtask

    task automatic test_streaming;
        logic        ev;
        logic [31:0] ef;
        int          k;
        for (int cyc = 1; cyc <= 14; cyc++) begin
            apply4(cyc <= 12, 8'(cyc - 1), 1'b1);
            ev = (cyc == 5) || (cyc == 9) || (cyc == 13);
            n_chk++; if (if4.o_rdy !== 1'b1) begin n_fail++; $display("FAIL stream_o_rdy cyc=%0d got=%0h exp=1", cyc, if4.o_rdy); end
            n_chk++; if (if4.o_vld !== ev) begin n_fail++; $display("FAIL stream_o_vld cyc=%0d got=%0h exp=%0h", cyc, if4.o_vld, ev); end
            if (ev) begin
                k  = (cyc - 5) / 4;
                ef = {8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
                n_chk++; if (if4.o_data !== ef) begin n_fail++; $display("FAIL stream_frame cyc=%0d got=%0h exp=%0h", cyc, if4.o_data, ef); end
            end
            adv4(cyc <= 12, 8'(cyc - 1), 1'b1);
        end
    endtask

    task automatic test_backpressure;
        for (int i = 1; i <= 4; i++) begin
            apply4(1'b1, 8'(i), 1'b1);
            adv4(1'b1, 8'(i), 1'b1);
        end
        for (int i = 5; i <= 7; i++) begin
            apply4(1'b1, 8'(i), 1'b0);
            n_chk++; if (if4.o_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_collect_rdy word=%0d got=%0h exp=1", i, if4.o_rdy); end
            n_chk++; if (if4.o_data !== 32'h04030201) begin n_fail++; $display("FAIL bp_hold_data word=%0d got=%0h exp=04030201", i, if4.o_data); end
            adv4(1'b1, 8'(i), 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            apply4(1'b1, 8'h08, 1'b0);
            n_chk++; if (if4.o_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_stall_rdy cyc=%0d got=%0h exp=0", i, if4.o_rdy); end
            n_chk++; if (if4.o_vld !== 1'b1) begin n_fail++; $display("FAIL bp_stall_vld cyc=%0d got=%0h exp=1", i, if4.o_vld); end
            n_chk++; if (if4.o_data !== 32'h04030201) begin n_fail++; $display("FAIL bp_stall_data cyc=%0d got=%0h exp=04030201", i, if4.o_data); end
            adv4(1'b1, 8'h08, 1'b0);
        end
        apply4(1'b1, 8'h08, 1'b1);
        n_chk++; if (if4.o_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy got=%0h exp=1", if4.o_rdy); end
        adv4(1'b1, 8'h08, 1'b1);
        apply4(1'b0, 8'h00, 1'b1);
        n_chk++; if (if4.o_vld !== 1'b1) begin n_fail++; $display("FAIL bp_next_vld got=%0h exp=1", if4.o_vld); end
        n_chk++; if (if4.o_data !== 32'h08070605) begin n_fail++; $display("FAIL bp_next_frame got=%0h exp=08070605", if4.o_data); end
        adv4(1'b0, 8'h00, 1'b1);
        apply4(1'b0, 8'h00, 1'b1);
        n_chk++; if (if4.o_vld !== 1'b0) begin n_fail++; $display("FAIL bp_drained_vld got=%0h exp=0", if4.o_vld); end
    endtask

    task automatic test_random;
        int         sent;
        int         recv;
        int         cyc;
        logic       v, r;
        logic [7:0] d;
        sent = 0;
        recv = 0;
        cyc  = 0;
        while ((sent < 1000 || m_frm.size() != 0) && cyc < 20000) begin
            v = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
            r = 1'($urandom_range(0, 1));
            d = 8'($urandom);
            apply4(v, d, r);
            n_chk++; if (if4.o_vld !== (m_frm.size() != 0)) begin n_fail++; $display("FAIL rand_o_vld cyc=%0d got=%0h exp=%0h", cyc, if4.o_vld, m_frm.size() != 0); end
            n_chk++; if (if4.o_rdy !== m_rdy(r)) begin n_fail++; $display("FAIL rand_o_rdy cyc=%0d got=%0h exp=%0h", cyc, if4.o_rdy, m_rdy(r)); end
            if (m_frm.size() != 0) begin
                n_chk++; if (if4.o_data !== m_frm[0]) begin n_fail++; $display("FAIL rand_frame cyc=%0d got=%0h exp=%0h", cyc, if4.o_data, m_frm[0]); end
                if (r) recv++;
            end
            if (v && m_rdy(r)) sent++;
            adv4(v, d, r);
            cyc++;
        end
        n_chk++; if (sent !== 1000) begin n_fail++; $display("FAIL rand_words_sent got=%0d exp=1000", sent); end
        n_chk++; if (recv !== 250) begin n_fail++; $display("FAIL rand_frames_recv got=%0d exp=250", recv); end
        apply4(1'b0, 8'h00, 1'b1);
        n_chk++; if (if4.o_vld !== 1'b0) begin n_fail++; $display("FAIL rand_drained_vld got=%0h exp=0", if4.o_vld); end
    endtask

    task automatic test_len1;
        logic [7:0] words [2];
        logic [7:0] m1[$];
        int         idx;
        int         recv;
        logic       v, r, er;
        words[0] = 8'hA5;
        words[1] = 8'h5A;
        idx  = 0;
        recv = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            v = (idx < 2);
            r = 1'(cyc % 2);
            if1.i_vld  = v;
            if1.i_data = v ? words[idx] : 8'hFF;
            if1.i_rdy  = r;
            #1;
            er = (m1.size() == 0) || r;
            n_chk++; if (if1.o_rdy !== er) begin n_fail++; $display("FAIL len1_o_rdy cyc=%0d got=%0h exp=%0h", cyc, if1.o_rdy, er); end
            n_chk++; if (if1.o_vld !== (m1.size() != 0)) begin n_fail++; $display("FAIL len1_o_vld cyc=%0d got=%0h exp=%0h", cyc, if1.o_vld, m1.size() != 0); end
            if (m1.size() != 0) begin
                n_chk++; if (if1.o_data !== m1[0]) begin n_fail++; $display("FAIL len1_data cyc=%0d got=%0h exp=%0h", cyc, if1.o_data, m1[0]); end
            end
            if ((m1.size() != 0) && r) begin
                void'(m1.pop_front());
                recv++;
            end
            if (v && er) begin
                m1.push_back(words[idx]);
                idx++;
            end
            tick();
        end
        if1.i_vld = 1'b0;
        if1.i_rdy = 1'b0;
        n_chk++; if (recv !== 2) begin n_fail++; $display("FAIL len1_recv got=%0d exp=2", recv); end
    endtask

`ifdef CM_DESER_LAST_EN
    task automatic test_last;
        apply4(1'b1, 8'h10, 1'b0);
        tick();
        if4.i_last = 1'b1;
        apply4(1'b1, 8'h20, 1'b0);
        tick();
        if4.i_last = 1'b0;
        apply4(1'b0, 8'h00, 1'b0);
        n_chk++; if (if4.o_vld !== 1'b1) begin n_fail++; $display("FAIL last_vld got=%0h exp=1", if4.o_vld); end
        n_chk++; if (if4.o_data !== 32'h00002010) begin n_fail++; $display("FAIL last_frame got=%0h exp=00002010", if4.o_data); end
        n_chk++; if (if4.o_cnt !== 3'd2) begin n_fail++; $display("FAIL last_cnt got=%0d exp=2", if4.o_cnt); end
        // a one-word frame must wait while the short frame is still held
        if4.i_last = 1'b1;
        apply4(1'b1, 8'h30, 1'b0);
        n_chk++; if (if4.o_rdy !== 1'b0) begin n_fail++; $display("FAIL last_gate_rdy got=%0h exp=0", if4.o_rdy); end
        tick();
        apply4(1'b1, 8'h30, 1'b1);
        n_chk++; if (if4.o_rdy !== 1'b1) begin n_fail++; $display("FAIL last_release_rdy got=%0h exp=1", if4.o_rdy); end
        tick();
        if4.i_last = 1'b0;
        apply4(1'b0, 8'h00, 1'b0);
        n_chk++; if (if4.o_data !== 32'h00000030) begin n_fail++; $display("FAIL last_one_frame got=%0h exp=00000030", if4.o_data); end
        n_chk++; if (if4.o_cnt !== 3'd1) begin n_fail++; $display("FAIL last_one_cnt got=%0d exp=1", if4.o_cnt); end
        for (int i = 0; i < 4; i++) begin
            apply4(1'b1, 8'hC1 + 8'(i), 1'b1);
            tick();
        end
        apply4(1'b0, 8'h00, 1'b1);
        n_chk++; if (if4.o_data !== 32'hC4C3C2C1) begin n_fail++; $display("FAIL last_full_frame got=%0h exp=c4c3c2c1", if4.o_data); end
        n_chk++; if (if4.o_cnt !== 3'd4) begin n_fail++; $display("FAIL last_full_cnt got=%0d exp=4", if4.o_cnt); end
        tick();
    endtask
`endif

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        rst_n      = 1'b1;
        if4.i_vld  = 1'b0;
        if4.i_data = '0;
        if4.i_rdy  = 1'b0;
        if1.i_vld  = 1'b0;
        if1.i_data = '0;
        if1.i_rdy  = 1'b0;
`ifdef CM_DESER_LAST_EN
        if4.i_last = 1'b0;
        if1.i_last = 1'b0;
`endif
        test_reset();
        test_streaming();
        test_backpressure();
        test_random();
        test_len1();
`ifdef CM_DESER_LAST_EN
        test_last();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
